// File: rtl/bmain_arbiter_if.sv
// rtl/bmain_arbiter_if.sv - bmain arbiter signal bundle (two requesters plus shared slave port)
interface bmain_arbiter_if;
    logic        m0_cvalid;
    logic        m0_cready;
    logic        m0_cmd;
    logic [25:0] m0_addr;
    logic        m0_rvalid;
    logic        m0_rready;
    logic        m0_rlast;
    logic [31:0] m0_rdata;
    logic        m0_error;
    logic        m0_eack;

    logic        m1_cvalid;
    logic        m1_cready;
    logic        m1_cmd;
    logic [25:0] m1_addr;
    logic        m1_rvalid;
    logic        m1_rready;
    logic        m1_rlast;
    logic [31:0] m1_rdata;
    logic        m1_error;
    logic        m1_eack;

    logic        bmain_cvalid;
    logic        bus_cready;
    logic        bmain_cmd;
    logic [25:0] bmain_addr;
    logic        bus_rvalid;
    logic        bmain_rready;
    logic        bus_rlast;
    logic [31:0] bus_rdata;
    logic        bus_error;
    logic        bmain_eack;

    // Arbiter view: serves the two requesters and drives the shared bmain slave port
    modport slave (
        input  m0_cvalid, m0_cmd, m0_addr, m0_rready, m0_eack,
        output m0_cready, m0_rvalid, m0_rlast, m0_rdata, m0_error,
        input  m1_cvalid, m1_cmd, m1_addr, m1_rready, m1_eack,
        output m1_cready, m1_rvalid, m1_rlast, m1_rdata, m1_error,
        output bmain_cvalid, bmain_cmd, bmain_addr, bmain_rready, bmain_eack,
        input  bus_cready, bus_rvalid, bus_rlast, bus_rdata, bus_error
    );

    // Environment view: the requesters and the bmain slave talking to the arbiter
    modport master (
        output m0_cvalid, m0_cmd, m0_addr, m0_rready, m0_eack,
        input  m0_cready, m0_rvalid, m0_rlast, m0_rdata, m0_error,
        output m1_cvalid, m1_cmd, m1_addr, m1_rready, m1_eack,
        input  m1_cready, m1_rvalid, m1_rlast, m1_rdata, m1_error,
        input  bmain_cvalid, bmain_cmd, bmain_addr, bmain_rready, bmain_eack,
        output bus_cready, bus_rvalid, bus_rlast, bus_rdata, bus_error
    );
endinterface

// File: rtl/bmain_arbiter.sv
// rtl/bmain_arbiter.sv - two-master bmain arbiter with burst ownership and no-response timeout
module bmain_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 1024,
    parameter int TO_W       = 11
) (
    input  logic           clk_core,
    input  logic           reset_n,
    bmain_arbiter_if.slave bif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_ERR
    } state_t;

    // Last counter value before the timeout fires; unused when TIMEOUT is 0
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_t          state, state_nxt;
    logic            owner, owner_nxt;       // 0 = m0, 1 = m1; meaningful outside IDLE only
    logic            rr_last, rr_nxt;        // master granted most recently
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
    logic            to_flag, to_flag_nxt;   // ERR was entered by timeout, not by slave error
    logic            cmd_q, cmd_nxt;
    logic [25:0]     addr_q, addr_nxt;

    logic            grant0, grant1;
    logic            tie_to_m0;
    logic            own_rready, own_eack;
    logic            beat_hs, to_hit;

    logic            o_rvalid, o_rlast, o_error;
    logic [31:0]     o_rdata;
    logic            cready0, cready1;
    logic            cvalid_o, rready_o, eack_o;

    // Owner-selected master inputs
    assign own_rready = owner ? bif.m1_rready : bif.m0_rready;
    assign own_eack   = owner ? bif.m1_eack   : bif.m0_eack;

    // Tie break: m0 wins under fixed priority, otherwise whoever was not granted last.
    // Grants are held off while reset is asserted so every output reads 0 in reset.
    assign tie_to_m0 = (FIXED_PRIO != 0) || rr_last;
    assign grant0    = reset_n & bif.m0_cvalid & (~bif.m1_cvalid | tie_to_m0);
    assign grant1    = reset_n & bif.m1_cvalid & ~grant0;

    assign beat_hs = bif.bus_rvalid & own_rready;
    assign to_hit  = (TIMEOUT != 0) && (to_cnt == TO_W'(TO_LAST));

    // Arbitration state register, latched command and timeout bookkeeping
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            owner   <= 1'b0;
            rr_last <= 1'b1;
            to_cnt  <= '0;
            to_flag <= 1'b0;
            cmd_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            rr_last <= rr_nxt;
            to_cnt  <= to_cnt_nxt;
            to_flag <= to_flag_nxt;
            cmd_q   <= cmd_nxt;
            addr_q  <= addr_nxt;
        end
    end

    // Next-state logic and owner-relative outputs
    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        rr_nxt      = rr_last;
        to_cnt_nxt  = to_cnt;
        to_flag_nxt = to_flag;
        cmd_nxt     = cmd_q;
        addr_nxt    = addr_q;
        cready0     = 1'b0;
        cready1     = 1'b0;
        cvalid_o    = 1'b0;
        rready_o    = 1'b0;
        eack_o      = 1'b0;
        o_rvalid    = 1'b0;
        o_rlast     = 1'b0;
        o_rdata     = '0;
        o_error     = 1'b0;

        case (state)
            ST_IDLE: begin
                cready0 = grant0;
                cready1 = grant1;
                if (grant0 || grant1) begin
                    cmd_nxt     = grant1 ? bif.m1_cmd  : bif.m0_cmd;
                    addr_nxt    = grant1 ? bif.m1_addr : bif.m0_addr;
                    owner_nxt   = grant1;
                    rr_nxt      = grant1;
                    to_cnt_nxt  = '0;
                    to_flag_nxt = 1'b0;
                    state_nxt   = ST_CMD;
                end
            end

            ST_CMD: begin
                cvalid_o = 1'b1;
                o_error  = bif.bus_error;
                if (bif.bus_error) begin
                    state_nxt = ST_ERR;
                end else if (bif.bus_cready) begin
                    to_cnt_nxt = '0;
                    state_nxt  = ST_DATA;
                end else if (to_hit) begin
                    to_flag_nxt = 1'b1;
                    state_nxt   = ST_ERR;
                end else if ((TIMEOUT != 0) && (to_cnt != TO_W'(TIMEOUT))) begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end

            ST_DATA: begin
                o_rvalid = bif.bus_rvalid;
                o_rlast  = bif.bus_rlast;
                o_rdata  = bif.bus_rdata;
                rready_o = own_rready;
                o_error  = bif.bus_error;
                // A slave error wins even over a coinciding last beat
                if (bif.bus_error) begin
                    state_nxt = ST_ERR;
                end else if (beat_hs && bif.bus_rlast) begin
                    state_nxt = ST_IDLE;
                end else if (beat_hs) begin
                    to_cnt_nxt = '0;
                end else if (to_hit) begin
                    to_flag_nxt = 1'b1;
                    state_nxt   = ST_ERR;
                end else if ((TIMEOUT != 0) && (to_cnt != TO_W'(TIMEOUT))) begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end

            ST_ERR: begin
                if (to_flag) begin
                    // Timeout: the slave never saw this error, so no eack goes out
                    o_error = 1'b1;
                    if (own_eack) begin
                        to_flag_nxt = 1'b0;
                        state_nxt   = ST_IDLE;
                    end
                end else begin
                    o_error = bif.bus_error;
                    eack_o  = own_eack;
                    if (bif.bus_error && own_eack) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bif.m0_cready    = cready0;
    assign bif.m1_cready    = cready1;

    assign bif.m0_rvalid    = ~owner & o_rvalid;
    assign bif.m0_rlast     = ~owner & o_rlast;
    assign bif.m0_rdata     = owner ? '0 : o_rdata;
    assign bif.m0_error     = ~owner & o_error;

    assign bif.m1_rvalid    = owner & o_rvalid;
    assign bif.m1_rlast     = owner & o_rlast;
    assign bif.m1_rdata     = owner ? o_rdata : '0;
    assign bif.m1_error     = owner & o_error;

    assign bif.bmain_cvalid = cvalid_o;
    assign bif.bmain_cmd    = cmd_q;
    assign bif.bmain_addr   = addr_q;
    assign bif.bmain_rready = rready_o;
    assign bif.bmain_eack   = eack_o;

endmodule

// File: tb/tb_bmain_arbiter.sv
// tb/tb_bmain_arbiter.sv - directed self-checking bench for bmain_arbiter
module tb_bmain_arbiter;

    logic clk_core = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   beats;

    bmain_arbiter_if bi ();
    bmain_arbiter_if bf ();

    bmain_arbiter #(.FIXED_PRIO(0), .TIMEOUT(8), .TO_W(4)) dut (
        .clk_core (clk_core),
        .reset_n  (reset_n),
        .bif      (bi.slave)
    );

    bmain_arbiter #(.FIXED_PRIO(1), .TIMEOUT(8), .TO_W(4)) dut_fp (
        .clk_core (clk_core),
        .reset_n  (reset_n),
        .bif      (bf.slave)
    );

    always #5 clk_core = ~clk_core;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] m0_outs();
        return 64'({bi.m0_cready, bi.m0_rvalid, bi.m0_rlast, bi.m0_rdata, bi.m0_error});
    endfunction

    function automatic logic [63:0] m1_outs();
        return 64'({bi.m1_cready, bi.m1_rvalid, bi.m1_rlast, bi.m1_rdata, bi.m1_error});
    endfunction

    function automatic logic [63:0] bm_outs();
        return 64'({bi.bmain_cvalid, bi.bmain_cmd, bi.bmain_addr, bi.bmain_rready, bi.bmain_eack});
    endfunction

    function automatic logic [31:0] get_rdata(input int who);
        return (who == 0) ? bi.m0_rdata : bi.m1_rdata;
    endfunction

    task automatic clr_bi();
        bi.m0_cvalid = 1'b0; bi.m0_cmd = 1'b0; bi.m0_addr = '0; bi.m0_rready = 1'b0; bi.m0_eack = 1'b0;
        bi.m1_cvalid = 1'b0; bi.m1_cmd = 1'b0; bi.m1_addr = '0; bi.m1_rready = 1'b0; bi.m1_eack = 1'b0;
        bi.bus_cready = 1'b0; bi.bus_rvalid = 1'b0; bi.bus_rlast = 1'b0; bi.bus_rdata = '0; bi.bus_error = 1'b0;
    endtask

    task automatic clr_bf();
        bf.m0_cvalid = 1'b0; bf.m0_cmd = 1'b0; bf.m0_addr = '0; bf.m0_rready = 1'b0; bf.m0_eack = 1'b0;
        bf.m1_cvalid = 1'b0; bf.m1_cmd = 1'b0; bf.m1_addr = '0; bf.m1_rready = 1'b0; bf.m1_eack = 1'b0;
        bf.bus_cready = 1'b0; bf.bus_rvalid = 1'b0; bf.bus_rlast = 1'b0; bf.bus_rdata = '0; bf.bus_error = 1'b0;
    endtask

    task automatic set_req(input int who, input logic [25:0] addr, input logic cmd);
        if (who == 0) begin
            bi.m0_cvalid = 1'b1; bi.m0_addr = addr; bi.m0_cmd = cmd;
        end else begin
            bi.m1_cvalid = 1'b1; bi.m1_addr = addr; bi.m1_cmd = cmd;
        end
    endtask

    task automatic set_rready(input int who, input logic v);
        if (who == 0) bi.m0_rready = v;
        else          bi.m1_rready = v;
    endtask

    // Entered with the DUT in CMD: slave takes the command, returns one last beat, DUT back to IDLE
    task automatic complete(input int who, input logic [31:0] data);
        @(negedge clk_core); clr_bi(); bi.bus_cready = 1'b1;
        @(negedge clk_core); clr_bi();
        bi.bus_rvalid = 1'b1; bi.bus_rlast = 1'b1; bi.bus_rdata = data; set_rready(who, 1'b1);
        #1 check("done_rdata", 64'(get_rdata(who)), 64'(data));
        @(negedge clk_core); clr_bi();
        #1 check("done_idle", 64'({bi.bmain_cvalid, bi.bmain_rready}), 64'd0);
    endtask

    logic [31:0] t3_data [7] = '{32'hB0, 32'hB1, 32'hB1, 32'hB1, 32'hB1, 32'hB2, 32'hB3};
    logic        t3_rdy  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        t3_last [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        reset_n = 1'b0;
        clr_bi();
        clr_bf();
        bi.m0_cvalid = 1'b1;

        // Reset: everything 0, even with a request pending
        @(negedge clk_core); @(negedge clk_core);
        #1;
        check("rst_m0", m0_outs(), 64'd0);
        check("rst_m1", m1_outs(), 64'd0);
        check("rst_bm", bm_outs(), 64'd0);
        @(negedge clk_core); reset_n = 1'b1; clr_bi();

        // Round-robin ties: first tie after reset to m0, next to m1
        @(negedge clk_core); clr_bi(); set_req(0, 26'hAAA, 1'b0); set_req(1, 26'hBBB, 1'b1);
        #1 check("tie1_m0_cready", 64'(bi.m0_cready), 64'd1);
        check("tie1_m1_cready", 64'(bi.m1_cready), 64'd0);
        @(negedge clk_core); clr_bi(); set_req(1, 26'hBBB, 1'b1);
        #1 check("tie1_addr", 64'(bi.bmain_addr), 64'h0AAA);
        check("tie1_cvalid", 64'(bi.bmain_cvalid), 64'd1);
        check("busy_m1_cready", 64'(bi.m1_cready), 64'd0);
        complete(0, 32'h11);
        @(negedge clk_core); clr_bi(); set_req(0, 26'hAAA, 1'b0); set_req(1, 26'hBBB, 1'b1);
        #1 check("tie2_m1_cready", 64'(bi.m1_cready), 64'd1);
        check("tie2_m0_cready", 64'(bi.m0_cready), 64'd0);
        @(negedge clk_core); clr_bi();
        #1 check("tie2_addr", 64'(bi.bmain_addr), 64'h0BBB);
        check("tie2_cmd", 64'(bi.bmain_cmd), 64'd1);
        complete(1, 32'h22);

        // m0 alone, 4-beat burst
        @(negedge clk_core); clr_bi(); set_req(0, 26'h0000100, 1'b0);
        #1 check("t1_cready", 64'(bi.m0_cready), 64'd1);
        check("t1_cvalid_lat", 64'(bi.bmain_cvalid), 64'd0);
        @(negedge clk_core); clr_bi(); bi.bus_cready = 1'b1;
        #1 check("t1_cvalid", 64'(bi.bmain_cvalid), 64'd1);
        check("t1_addr", 64'(bi.bmain_addr), 64'h100);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_core); clr_bi();
            bi.bus_rvalid = 1'b1; bi.bus_rdata = 32'hA0 + 32'(k); bi.bus_rlast = (k == 3); bi.m0_rready = 1'b1;
            #1 check("t1_rvalid", 64'(bi.m0_rvalid), 64'd1);
            check("t1_rdata", 64'(bi.m0_rdata), 64'(32'hA0 + 32'(k)));
            check("t1_rlast", 64'(bi.m0_rlast), (k == 3) ? 64'd1 : 64'd0);
            check("t1_rready", 64'(bi.bmain_rready), 64'd1);
            check("t1_m1_quiet", m1_outs(), 64'd0);
        end
        @(negedge clk_core); clr_bi();
        #1 check("t1_idle_m0", m0_outs(), 64'd0);
        check("t1_idle_cvalid", 64'(bi.bmain_cvalid), 64'd0);

        // m1 burst with rready held low 3 cycles on beat 1
        @(negedge clk_core); clr_bi(); set_req(1, 26'h2345, 1'b0);
        #1 check("t3_cready", 64'(bi.m1_cready), 64'd1);
        @(negedge clk_core); clr_bi(); bi.bus_cready = 1'b1;
        beats = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk_core); clr_bi();
            bi.bus_rvalid = 1'b1; bi.bus_rdata = t3_data[k]; bi.bus_rlast = t3_last[k]; bi.m1_rready = t3_rdy[k];
            #1 check("t3_rvalid", 64'(bi.m1_rvalid), 64'd1);
            check("t3_rdata", 64'(bi.m1_rdata), 64'(t3_data[k]));
            check("t3_rready", 64'(bi.bmain_rready), 64'(t3_rdy[k]));
            check("t3_m0_quiet", m0_outs(), 64'd0);
            if (bi.bmain_rready && bi.bus_rvalid) beats++;
        end
        check("t3_beats", 64'(beats), 64'd4);
        @(negedge clk_core); clr_bi();
        #1 check("t3_idle", 64'(bi.m1_rvalid), 64'd0);

        // Slave error on beat 2 of an m0 burst
        @(negedge clk_core); clr_bi(); set_req(0, 26'h40, 1'b0);
        @(negedge clk_core); clr_bi(); bi.bus_cready = 1'b1;
        @(negedge clk_core); clr_bi(); bi.bus_rvalid = 1'b1; bi.bus_rdata = 32'hC0; bi.m0_rready = 1'b1;
        #1 check("t4_beat1", 64'(bi.m0_rdata), 64'hC0);
        @(negedge clk_core); clr_bi();
        bi.bus_rvalid = 1'b1; bi.bus_rdata = 32'hC1; bi.m0_rready = 1'b1; bi.bus_error = 1'b1;
        #1 check("t4_err_beat", 64'({bi.m0_error, bi.m0_rvalid}), 64'b11);
        check("t4_m1_err", 64'(bi.m1_error), 64'd0);
        @(negedge clk_core); clr_bi(); bi.bus_error = 1'b1;
        #1 check("t4_err_hold", 64'({bi.m0_error, bi.m0_rvalid, bi.bmain_eack, bi.bmain_rready}), 64'b1000);
        @(negedge clk_core); clr_bi(); bi.bus_error = 1'b1; bi.m0_eack = 1'b1;
        #1 check("t4_eack", 64'({bi.m0_error, bi.bmain_eack}), 64'b11);
        @(negedge clk_core); clr_bi();
        #1 check("t4_idle", m0_outs(), 64'd0);
        check("t4_idle_eack", 64'(bi.bmain_eack), 64'd0);
        @(negedge clk_core); clr_bi(); set_req(0, 26'h3, 1'b0);
        #1 check("t4_reaccept", 64'(bi.m0_cready), 64'd1);
        complete(0, 32'h33);

        // Timeout: slave never accepts m1's command
        @(negedge clk_core); clr_bi(); set_req(1, 26'h77, 1'b1);
        #1 check("t5_cready", 64'(bi.m1_cready), 64'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_core); clr_bi();
            #1 check("t5_wait", 64'({bi.m1_error, bi.bmain_cvalid}), 64'b01);
        end
        @(negedge clk_core); clr_bi();
        #1 check("t5_err", 64'({bi.m1_error, bi.bmain_cvalid, bi.m0_error}), 64'b100);
        @(negedge clk_core); clr_bi(); bi.m1_eack = 1'b1;
        #1 check("t5_eack", 64'({bi.m1_error, bi.bmain_eack}), 64'b10);
        @(negedge clk_core); clr_bi();
        #1 check("t5_idle", m1_outs(), 64'd0);

        // Fixed priority instance: m0 wins both ties
        @(negedge clk_core); clr_bf(); bf.m0_cvalid = 1'b1; bf.m1_cvalid = 1'b1;
        #1 check("fp_tie1", 64'({bf.m0_cready, bf.m1_cready}), 64'b10);
        @(negedge clk_core); clr_bf(); bf.bus_cready = 1'b1;
        @(negedge clk_core); clr_bf(); bf.bus_rvalid = 1'b1; bf.bus_rlast = 1'b1; bf.m0_rready = 1'b1;
        @(negedge clk_core); clr_bf(); bf.m0_cvalid = 1'b1; bf.m1_cvalid = 1'b1;
        #1 check("fp_tie2", 64'({bf.m0_cready, bf.m1_cready}), 64'b10);
        @(negedge clk_core); clr_bf(); bf.bus_cready = 1'b1;
        @(negedge clk_core); clr_bf(); bf.bus_rvalid = 1'b1; bf.bus_rlast = 1'b1; bf.m0_rready = 1'b1;
        @(negedge clk_core); clr_bf();

        // Reset during DATA beat 2, then a fresh tie goes to m0 again
        @(negedge clk_core); clr_bi(); set_req(0, 26'h55, 1'b1);
        @(negedge clk_core); clr_bi(); bi.bus_cready = 1'b1;
        @(negedge clk_core); clr_bi(); bi.bus_rvalid = 1'b1; bi.bus_rdata = 32'hD0; bi.m0_rready = 1'b1;
        @(negedge clk_core); clr_bi();
        bi.bus_rvalid = 1'b1; bi.bus_rdata = 32'hD1; bi.m0_rready = 1'b1; bi.m1_cvalid = 1'b1;
        #1 check("t6_pre", 64'(bi.m0_rdata), 64'hD1);
        reset_n = 1'b0;
        #1 check("t6_m0", m0_outs(), 64'd0);
        check("t6_m1", m1_outs(), 64'd0);
        check("t6_bm", bm_outs(), 64'd0);
        @(negedge clk_core); reset_n = 1'b1; clr_bi();
        @(negedge clk_core); clr_bi(); set_req(0, 26'h66, 1'b0); set_req(1, 26'h67, 1'b0);
        #1 check("t6_tie", 64'({bi.m0_cready, bi.m1_cready}), 64'b10);
        @(negedge clk_core); clr_bi();
        #1 check("t6_addr", 64'(bi.bmain_addr), 64'h66);
        complete(0, 32'h44);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
